operand_stage: RTL

- Datapath storage stage driven directly by the multi-cycle control FSM. It consumes that FSM's R1R2Load, R1Sel, RFWrite, RegIn, ALUOutWrite, MDRload and FlagWrite outputs.
- Holds the architectural register file, the R1/R2 operand latches, ALUOut, MDR and the N/Z flag register.
- Its N and Z outputs feed back to the FSM for branch decisions.

---
 rtl/operand_stage_pkg.sv | 11 +
 rtl/operand_stage_regfile.sv | 43 ++++
 rtl/operand_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/operand_stage_pkg.sv
// rtl/operand_stage_pkg.sv - shared widths, ORI target index and RegIn encodings
package operand_stage_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_AW  = 2;
    localparam int ORI_REG = 1;

    localparam logic REGIN_ALU = 1'b0;
    localparam logic REGIN_MDR = 1'b1;

endpackage

// File: rtl/operand_stage_regfile.sv
// rtl/operand_stage_regfile.sv - 2-read/1-write register array, async clear, combinational reads
module regfile_2r1w #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic [AW-1:0]          rd1_addr,
    output logic [DW-1:0]          rd1_data,
    input  logic [AW-1:0]          rd2_addr,
    output logic [DW-1:0]          rd2_data,
    output logic [DW*(2**AW)-1:0]  flat
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-edge contents, so a same-edge write is not bypassed.
    assign rd1_data = mem[rd1_addr];
    assign rd2_data = mem[rd2_addr];

    always_comb begin
        flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            flat[i*DW +: DW] = mem[i];
        end
    end

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - register file, operand latches, ALUOut, MDR and N/Z flags
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int DATA_W  = operand_stage_pkg::DATA_W,
    parameter int REG_AW  = operand_stage_pkg::REG_AW,
    parameter int ORI_REG = operand_stage_pkg::ORI_REG
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [REG_AW-1:0]             ir_ra,
    input  logic [REG_AW-1:0]             ir_rb,
    input  logic                          R1R2Load,
    input  logic                          R1Sel,
    input  logic                          RFWrite,
    input  logic                          RegIn,
    input  logic                          ALUOutWrite,
    input  logic                          MDRload,
    input  logic                          FlagWrite,
    input  logic [DATA_W-1:0]             alu_result,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [DATA_W-1:0]             R1,
    output logic [DATA_W-1:0]             R2,
    output logic [DATA_W-1:0]             ALUOut,
    output logic [DATA_W-1:0]             MDR,
    output logic                          N,
    output logic                          Z,
    output logic [DATA_W*(2**REG_AW)-1:0] reg_dbg
);

    logic [REG_AW-1:0] port1_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;

    // R1Sel redirects both the port-1 read and the write to the implicit ORI target.
    assign port1_addr = R1Sel ? REG_AW'(ORI_REG) : ir_ra;
    assign wr_data    = (RegIn == REGIN_MDR) ? MDR : ALUOut;

    regfile_2r1w #(
        .DW (DATA_W),
        .AW (REG_AW)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (RFWrite),
        .wr_addr  (port1_addr),
        .wr_data  (wr_data),
        .rd1_addr (port1_addr),
        .rd1_data (rd1_data),
        .rd2_addr (ir_rb),
        .rd2_data (rd2_data),
        .flat     (reg_dbg)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            R1     <= '0;
            R2     <= '0;
            ALUOut <= '0;
            MDR    <= '0;
            N      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            if (R1R2Load) begin
                R1 <= rd1_data;
                R2 <= rd2_data;
            end
            if (ALUOutWrite) begin
                ALUOut <= alu_result;
            end
            if (MDRload) begin
                MDR <= mem_rdata;
            end
            // Flags hold otherwise; branch states read them long after the ALU op.
            if (FlagWrite) begin
                N <= alu_result[DATA_W-1];
                Z <= (alu_result == '0);
            end
        end
    end

endmodule
